// File: rtl/conv_fprop1_mul_pkg.sv
// rtl/conv_fprop1_mul_pkg.sv - shared widths, bounds and limits for the conv_fprop1 multiplier
// Purpose: product width helper, saturation bound helpers, stage-count limit.
// Ports: none (package).
package conv_fprop1_mul_pkg;

    localparam int MAX_NUM_STAGE = 8;

    // Operands are each widened by one bit before a signed multiply, so the
    // full product can never overflow.
    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

    // Bounds are returned in a 64-bit container; callers keep the low w bits.
    function automatic logic [63:0] smax_bound(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin_bound(input int w);
        return {64{1'b1}} << (w - 1);
    endfunction

    function automatic logic [63:0] umax_bound(input int w);
        return (w >= 64) ? {64{1'b1}} : (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] max_bound(input int w, input bit sgn);
        return sgn ? smax_bound(w) : umax_bound(w);
    endfunction

    function automatic logic [63:0] min_bound(input int w, input bit sgn);
        return sgn ? smin_bound(w) : 64'd0;
    endfunction

endpackage

// File: rtl/conv_fprop1_mul_sat.sv
// rtl/conv_fprop1_mul_sat.sv - combinational resize of a signed value with overflow flag
// Purpose: fit a two's complement value into OW bits, signed or unsigned range.
// Ports: din (IW, signed) in; dout (OW) out; ovf out = value was out of range.
module conv_fprop1_mul_sat
    import conv_fprop1_mul_pkg::*;
#(
    parameter int IW  = 19,
    parameter int OW  = 16,
    parameter int SGN = 0,
    parameter int SAT = 1
) (
    input  logic signed [IW-1:0] din,
    output logic        [OW-1:0] dout,
    output logic                 ovf
);

    localparam logic [63:0]   HI_F = max_bound(OW, SGN != 0);
    localparam logic [63:0]   LO_F = min_bound(OW, SGN != 0);
    localparam logic [OW-1:0] HI   = HI_F[OW-1:0];
    localparam logic [OW-1:0] LO   = LO_F[OW-1:0];

    logic [OW-1:0] trunc;
    logic          too_big;
    logic          too_small;

    if (SGN != 0) begin : g_signed
        if (IW > OW) begin : g_narrow
            // In range only when every bit from the output sign bit upward agrees.
            logic [IW-OW:0] top_bits;
            assign top_bits  = din[IW-1:OW-1];
            assign too_big   = !top_bits[IW-OW] && (|top_bits);
            assign too_small = top_bits[IW-OW] && !(&top_bits);
            assign trunc     = din[OW-1:0];
        end else begin : g_wide
            assign too_big   = 1'b0;
            assign too_small = 1'b0;
            assign trunc     = OW'(din);
        end
    end else begin : g_unsigned
        assign too_small = din[IW-1];
        if (IW - 1 > OW) begin : g_narrow
            assign too_big = !din[IW-1] && (|din[IW-2:OW]);
        end else begin : g_wide
            assign too_big = 1'b0;
        end
        if (IW >= OW) begin : g_trunc
            assign trunc = din[OW-1:0];
        end else begin : g_ext
            assign trunc = OW'(din);
        end
    end

    assign ovf  = too_big || too_small;
    assign dout = (SAT != 0 && too_big)   ? HI :
                  (SAT != 0 && too_small) ? LO : trunc;

endmodule

// File: rtl/conv_fprop1_mul_pipe_sat.sv
// rtl/conv_fprop1_mul_pipe_sat.sv - pipelined saturating multiplier / MAC for one conv_fprop1 lane
// Purpose: din0*din1 through NUM_STAGE registers, resized to dout_WIDTH, optional accumulate.
// Ports: clk, reset (sync, active-high), ce (stall); din0, din1, din_vld, acc_clr in;
//        dout, dout_vld, ovf out (updated only when a valid sample leaves the pipe).
module conv_fprop1_mul_pipe_sat
    import conv_fprop1_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 11,
    parameter int din1_WIDTH  = 6,
    parameter int dout_WIDTH  = 16,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int SAT_EN      = 1,
    parameter int ACC_EN      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din_vld,
    input  logic                  acc_clr,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  ovf
);

    localparam int PW   = prod_width(din0_WIDTH, din1_WIDTH);
    localparam bit OSGN = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    // Sum width covers both the accumulator and the product plus a carry bit.
    localparam int SW   = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 1;

    if (NUM_STAGE < 1 || NUM_STAGE > MAX_NUM_STAGE || ID < 0) begin : g_bad_cfg
        $error("conv_fprop1_mul_pipe_sat: NUM_STAGE must be 1..8 and ID non-negative");
    end

    logic signed [din0_WIDTH:0] a_ext;
    logic signed [din1_WIDTH:0] b_ext;
    logic signed [PW-1:0]       prod_in;

    assign a_ext   = {(DIN0_SIGNED != 0) && din0[din0_WIDTH-1], din0};
    assign b_ext   = {(DIN1_SIGNED != 0) && din1[din1_WIDTH-1], din1};
    assign prod_in = PW'(a_ext) * PW'(b_ext);

    logic signed [PW-1:0] last_data;
    logic                 last_vld;
    logic                 last_clr;

    // The output register is the final stage, so only NUM_STAGE-1 product
    // registers sit in front of it.
    if (NUM_STAGE == 1) begin : g_direct
        assign last_data = prod_in;
        assign last_vld  = din_vld;
        assign last_clr  = acc_clr;
    end else begin : g_pipe
        logic signed [PW-1:0] st_data [NUM_STAGE-1];
        logic                 st_vld  [NUM_STAGE-1];
        logic                 st_clr  [NUM_STAGE-1];

        for (genvar g = 0; g < NUM_STAGE - 1; g++) begin : g_stage
            if (g == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        st_vld[0] <= 1'b0;
                    end else if (ce) begin
                        st_vld[0] <= din_vld;
                    end
                    if (ce) begin
                        st_data[0] <= prod_in;
                        st_clr[0]  <= acc_clr;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) begin
                        st_vld[g] <= 1'b0;
                    end else if (ce) begin
                        st_vld[g] <= st_vld[g-1];
                    end
                    if (ce) begin
                        st_data[g] <= st_data[g-1];
                        st_clr[g]  <= st_clr[g-1];
                    end
                end
            end
        end

        assign last_data = st_data[NUM_STAGE-2];
        assign last_vld  = st_vld[NUM_STAGE-2];
        assign last_clr  = st_clr[NUM_STAGE-2];
    end

    logic [dout_WIDTH-1:0] res;
    logic                  res_ovf;

    if (ACC_EN != 0) begin : g_mac
        // dout doubles as the accumulator; a clear sample adds to zero instead.
        logic signed [SW-1:0] acc_ext;
        logic signed [SW-1:0] prod_ext;
        logic signed [SW-1:0] sum;

        assign acc_ext  = last_clr ? '0 :
                          {{(SW-dout_WIDTH){OSGN && dout[dout_WIDTH-1]}}, dout};
        assign prod_ext = SW'(last_data);
        assign sum      = acc_ext + prod_ext;

        conv_fprop1_mul_sat #(
            .IW  (SW),
            .OW  (dout_WIDTH),
            .SGN (OSGN ? 1 : 0),
            .SAT (SAT_EN)
        ) u_sat (
            .din  (sum),
            .dout (res),
            .ovf  (res_ovf)
        );
    end else begin : g_mul
        logic unused_clr;
        assign unused_clr = last_clr;

        conv_fprop1_mul_sat #(
            .IW  (PW),
            .OW  (dout_WIDTH),
            .SGN (OSGN ? 1 : 0),
            .SAT (SAT_EN)
        ) u_sat (
            .din  (last_data),
            .dout (res),
            .ovf  (res_ovf)
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            ovf      <= 1'b0;
            dout_vld <= 1'b0;
        end else if (ce) begin
            dout_vld <= last_vld;
            if (last_vld) begin
                dout <= res;
                ovf  <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_conv_fprop1_mul_pipe_sat.sv
// tb/tb_conv_fprop1_mul_pipe_sat.sv - directed self-checking bench for conv_fprop1_mul_pipe_sat
module tb_conv_fprop1_mul_pipe_sat;

    logic        clk = 1'b0;
    logic        reset, ce, din_vld, acc_clr;
    logic [10:0] din0;
    logic [5:0]  din1;

    logic [15:0] dout_def, dout_sgn, dout_trc, dout_mac, dout_s1, dout_s8;
    logic        vld_def, vld_sgn, vld_trc, vld_mac, vld_s1, vld_s8;
    logic        ovf_def, ovf_sgn, ovf_trc, ovf_mac, ovf_s1, ovf_s8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conv_fprop1_mul_pipe_sat u_def (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .acc_clr(acc_clr),
        .dout(dout_def), .dout_vld(vld_def), .ovf(ovf_def));

    conv_fprop1_mul_pipe_sat #(.DIN0_SIGNED(1), .SAT_EN(1)) u_sgn (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .acc_clr(acc_clr),
        .dout(dout_sgn), .dout_vld(vld_sgn), .ovf(ovf_sgn));

    conv_fprop1_mul_pipe_sat #(.DIN0_SIGNED(1), .SAT_EN(0)) u_trc (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .acc_clr(acc_clr),
        .dout(dout_trc), .dout_vld(vld_trc), .ovf(ovf_trc));

    conv_fprop1_mul_pipe_sat #(.ACC_EN(1)) u_mac (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .acc_clr(acc_clr),
        .dout(dout_mac), .dout_vld(vld_mac), .ovf(ovf_mac));

    conv_fprop1_mul_pipe_sat #(.NUM_STAGE(1)) u_s1 (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .acc_clr(acc_clr),
        .dout(dout_s1), .dout_vld(vld_s1), .ovf(ovf_s1));

    conv_fprop1_mul_pipe_sat #(.NUM_STAGE(8)) u_s8 (
        .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
        .din_vld(din_vld), .acc_clr(acc_clr),
        .dout(dout_s8), .dout_vld(vld_s8), .ovf(ovf_s8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] a, input logic [5:0] b, input logic v, input logic c);
        din0    = a;
        din1    = b;
        din_vld = v;
        acc_clr = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce    = 1'b1;
        drive(11'd0, 6'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b0;
        drive(11'd0, 6'd0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (dout_def !== 16'd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout_def); end
        checks++; if (vld_def !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0d expected 0", vld_def); end
        checks++; if (ovf_def !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", ovf_def); end
        checks++; if (dout_mac !== 16'd0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", dout_mac); end
        checks++; if (vld_s8 !== 1'b0) begin errors++; $display("FAIL reset_vld_s8: got %0d expected 0", vld_s8); end
        reset = 1'b0;
        ce    = 1'b1;
    endtask

    task automatic test_unsigned();
        do_reset();
        drive(11'd1000, 6'd50, 1'b1, 1'b0);
        tick();
        checks++; if (vld_s1 !== 1'b1 || dout_s1 !== 16'd50000) begin errors++; $display("FAIL s1_latency: got vld=%0d dout=%0d expected vld=1 dout=50000", vld_s1, dout_s1); end
        checks++; if (vld_def !== 1'b0) begin errors++; $display("FAIL def_early_vld: got %0d expected 0", vld_def); end
        drive(11'd2047, 6'd63, 1'b1, 1'b0);
        tick();
        checks++; if (dout_s1 !== 16'd65535 || ovf_s1 !== 1'b1) begin errors++; $display("FAIL s1_sat: got dout=%0d ovf=%0d expected 65535/1", dout_s1, ovf_s1); end
        drive(11'd0, 6'd0, 1'b0, 1'b0);
        tick();
        checks++; if (vld_def !== 1'b1 || dout_def !== 16'd50000 || ovf_def !== 1'b0) begin errors++; $display("FAIL def_product: got vld=%0d dout=%0d ovf=%0d expected 1/50000/0", vld_def, dout_def, ovf_def); end
        tick();
        checks++; if (vld_def !== 1'b1 || dout_def !== 16'd65535 || ovf_def !== 1'b1) begin errors++; $display("FAIL def_sat: got vld=%0d dout=%0d ovf=%0d expected 1/65535/1", vld_def, dout_def, ovf_def); end
        tick();
        checks++; if (vld_def !== 1'b0 || dout_def !== 16'd65535 || ovf_def !== 1'b1) begin errors++; $display("FAIL def_bubble_hold: got vld=%0d dout=%0d ovf=%0d expected 0/65535/1", vld_def, dout_def, ovf_def); end
    endtask

    task automatic test_signed();
        logic [10:0] a_tab [3] = '{11'h400, 11'h7FF, 11'd1000};
        logic [5:0]  b_tab [3] = '{6'd63, 6'd63, 6'd50};
        logic [15:0] s_exp [3] = '{16'h8000, 16'hFFC1, 16'h7FFF};
        logic        s_ovf [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] t_exp [3] = '{16'h0400, 16'hFFC1, 16'hC350};
        do_reset();
        for (int t = 1; t <= 5; t++) begin
            if (t <= 3) drive(a_tab[t-1], b_tab[t-1], 1'b1, 1'b0);
            else        drive(11'd0, 6'd0, 1'b0, 1'b0);
            tick();
            if (t >= 3) begin
                checks++; if (dout_sgn !== s_exp[t-3] || ovf_sgn !== s_ovf[t-3]) begin errors++; $display("FAIL signed_sat[%0d]: got dout=%0h ovf=%0d expected %0h/%0d", t-3, dout_sgn, ovf_sgn, s_exp[t-3], s_ovf[t-3]); end
                checks++; if (dout_trc !== t_exp[t-3] || ovf_trc !== s_ovf[t-3]) begin errors++; $display("FAIL signed_trunc[%0d]: got dout=%0h ovf=%0d expected %0h/%0d", t-3, dout_trc, ovf_trc, t_exp[t-3], s_ovf[t-3]); end
            end
            if (t == 3) begin
                checks++; if (dout_def !== 16'd64512 || ovf_def !== 1'b0) begin errors++; $display("FAIL unsigned_1024x63: got dout=%0d ovf=%0d expected 64512/0", dout_def, ovf_def); end
            end
        end
    endtask

    task automatic test_ce_stall();
        logic [15:0] pv [3];
        int          pt [3];
        int          np = 0;
        do_reset();
        for (int t = 1; t <= 12; t++) begin
            ce = !(t >= 3 && t <= 6);
            if (t == 1)      drive(11'd1, 6'd1, 1'b1, 1'b0);
            else if (t == 2) drive(11'd2, 6'd2, 1'b1, 1'b0);
            else if (t <= 7) drive(11'd3, 6'd3, 1'b1, 1'b0);
            else             drive(11'd0, 6'd0, 1'b0, 1'b0);
            tick();
            if (ce && vld_def) begin
                if (np < 3) begin
                    pv[np] = dout_def;
                    pt[np] = t;
                end
                np++;
            end
        end
        ce = 1'b1;
        checks++; if (np !== 3) begin errors++; $display("FAIL stall_pulse_count: got %0d expected 3", np); end
        for (int i = 0; i < 3; i++) begin
            if (i < np) begin
                checks++; if (pv[i] !== 16'((i + 1) * (i + 1))) begin errors++; $display("FAIL stall_value[%0d]: got %0d expected %0d", i, pv[i], (i + 1) * (i + 1)); end
                checks++; if (pt[i] !== 7 + i) begin errors++; $display("FAIL stall_time[%0d]: got tick %0d expected tick %0d", i, pt[i], 7 + i); end
            end
        end
    endtask

    task automatic test_mac();
        logic [10:0] a_tab [8] = '{11'd100, 11'd100, 11'd0, 11'd100, 11'd100, 11'd5, 11'd0, 11'd1};
        logic [5:0]  b_tab [8] = '{6'd10, 6'd10, 6'd0, 6'd10, 6'd10, 6'd5, 6'd0, 6'd1};
        logic        v_tab [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        c_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] d_exp [8] = '{16'd1000, 16'd2000, 16'd2000, 16'd3000, 16'd4000, 16'd25, 16'd25, 16'd26};
        do_reset();
        for (int t = 1; t <= 10; t++) begin
            if (t <= 8) drive(a_tab[t-1], b_tab[t-1], v_tab[t-1], c_tab[t-1]);
            else        drive(11'd0, 6'd0, 1'b0, 1'b0);
            tick();
            if (t >= 3) begin
                checks++; if (vld_mac !== v_tab[t-3]) begin errors++; $display("FAIL mac_vld[%0d]: got %0d expected %0d", t-3, vld_mac, v_tab[t-3]); end
                checks++; if (dout_mac !== d_exp[t-3] || ovf_mac !== 1'b0) begin errors++; $display("FAIL mac_dout[%0d]: got dout=%0d ovf=%0d expected %0d/0", t-3, dout_mac, ovf_mac, d_exp[t-3]); end
            end
        end
    endtask

    task automatic test_mac_sat();
        logic [10:0] a_tab [4] = '{11'd1625, 11'd1000, 11'd2, 11'd1};
        logic [5:0]  b_tab [4] = '{6'd40, 6'd1, 6'd3, 6'd1};
        logic        c_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] d_exp [4] = '{16'd65000, 16'd65535, 16'd65535, 16'd1};
        logic        o_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int t = 1; t <= 6; t++) begin
            if (t <= 4) drive(a_tab[t-1], b_tab[t-1], 1'b1, c_tab[t-1]);
            else        drive(11'd0, 6'd0, 1'b0, 1'b0);
            tick();
            if (t >= 3) begin
                checks++; if (vld_mac !== 1'b1 || dout_mac !== d_exp[t-3] || ovf_mac !== o_exp[t-3]) begin errors++; $display("FAIL mac_sat[%0d]: got vld=%0d dout=%0d ovf=%0d expected 1/%0d/%0d", t-3, vld_mac, dout_mac, ovf_mac, d_exp[t-3], o_exp[t-3]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int lat_def = 0, lat_s1 = 0, lat_s8 = 0, lat_mac = 0;
        logic [15:0] val_def = 0, val_s1 = 0, val_s8 = 0, val_mac = 0;
        logic seen_vld = 1'b0;
        do_reset();
        drive(11'd100, 6'd10, 1'b1, 1'b1);
        tick();
        drive(11'd200, 6'd10, 1'b1, 1'b0);
        tick();
        // Reset asserted together with ce=0 and a valid sample: reset must win.
        drive(11'd300, 6'd10, 1'b1, 1'b0);
        ce    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ce    = 1'b1;
        drive(11'd0, 6'd0, 1'b0, 1'b0);
        checks++; if (vld_def !== 1'b0 || dout_def !== 16'd0 || ovf_def !== 1'b0) begin errors++; $display("FAIL midflight_def: got vld=%0d dout=%0d ovf=%0d expected 0/0/0", vld_def, dout_def, ovf_def); end
        checks++; if (vld_s1 !== 1'b0 || dout_s1 !== 16'd0) begin errors++; $display("FAIL midflight_s1: got vld=%0d dout=%0d expected 0/0", vld_s1, dout_s1); end
        checks++; if (dout_mac !== 16'd0) begin errors++; $display("FAIL midflight_acc: got %0d expected 0", dout_mac); end
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (vld_def || vld_s1 || vld_s8 || vld_mac) seen_vld = 1'b1;
        end
        checks++; if (seen_vld !== 1'b0) begin errors++; $display("FAIL flushed_vld: got %0d expected 0", seen_vld); end
        drive(11'd7, 6'd9, 1'b1, 1'b0);
        for (int t = 1; t <= 10; t++) begin
            tick();
            drive(11'd0, 6'd0, 1'b0, 1'b0);
            if (vld_def && lat_def == 0) begin lat_def = t; val_def = dout_def; end
            if (vld_s1  && lat_s1  == 0) begin lat_s1  = t; val_s1  = dout_s1;  end
            if (vld_s8  && lat_s8  == 0) begin lat_s8  = t; val_s8  = dout_s8;  end
            if (vld_mac && lat_mac == 0) begin lat_mac = t; val_mac = dout_mac; end
        end
        checks++; if (lat_def !== 3 || val_def !== 16'd63) begin errors++; $display("FAIL post_reset_def: got tick=%0d dout=%0d expected 3/63", lat_def, val_def); end
        checks++; if (lat_s1 !== 1 || val_s1 !== 16'd63) begin errors++; $display("FAIL post_reset_s1: got tick=%0d dout=%0d expected 1/63", lat_s1, val_s1); end
        checks++; if (lat_s8 !== 8 || val_s8 !== 16'd63) begin errors++; $display("FAIL post_reset_s8: got tick=%0d dout=%0d expected 8/63", lat_s8, val_s8); end
        checks++; if (lat_mac !== 3 || val_mac !== 16'd63) begin errors++; $display("FAIL post_reset_mac: got tick=%0d dout=%0d expected 3/63", lat_mac, val_mac); end
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b0;
        drive(11'd0, 6'd0, 1'b0, 1'b0);
        test_reset();
        test_unsigned();
        test_signed();
        test_ce_stall();
        test_mac();
        test_mac_sat();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
